// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants: opcodes, instruction fields, fetch FSM states
package pipe_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_LOAD = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 2;
  localparam int IMM_LO = 0;

  typedef logic [1:0] state_t;

  localparam state_t S_FETCH  = 2'd0;
  localparam state_t S_WAIT   = 2'd1;
  localparam state_t S_DRAIN  = 2'd2;
  localparam state_t S_HALTED = 2'd3;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[OP_HI:OP_LO] == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch unit bus: instruction memory, decode handoff, redirect
interface instr_fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int IMEM_AW = 4
);

  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_ack;
  logic [15:0]        imem_rdata;

  logic               if_valid;
  logic [15:0]        if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               id_ready;

  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output if_valid, if_instr, if_pc, halted,
    input  id_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  if_valid, if_instr, if_pc, halted,
    output id_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - fetch buffer, synchronous FIFO with flush; head is combinational
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // Popping frees a slot in the same cycle, so a push at full is accepted alongside a pop
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // Masked while empty so stale entries never reach the decode stage
  assign head_data = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch: one outstanding imem request, fetch buffer, redirect/halt
module instr_fetch_unit
  import pipe_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int IMEM_AW = 4,
  parameter int DEPTH   = 4
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = PC_W + 16;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               req_q, req_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;

  logic               fifo_push, fifo_pop, fifo_flush;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [DW-1:0]      fifo_head;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.redirect) begin
          fifo_flush = 1'b1;
          pc_d       = bus.redirect_pc;
        end else if (fifo_count < CW'(DEPTH)) begin
          req_d   = 1'b1;
          addr_d  = pc_q[IMEM_AW-1:0];
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect) begin
          fifo_flush = 1'b1;
          pc_d       = bus.redirect_pc;
          if (bus.imem_ack) begin
            req_d   = 1'b0;
            state_d = S_FETCH;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (bus.imem_ack) begin
          fifo_push = !fifo_full || fifo_pop;
          pc_d      = pc_q + PC_W'(1);
          req_d     = 1'b0;
          state_d   = is_halt(bus.imem_rdata) ? S_HALTED : S_FETCH;
        end
      end
      S_DRAIN: begin
        if (bus.redirect) begin
          fifo_flush = 1'b1;
          pc_d       = bus.redirect_pc;
        end
        // The stale request completes regardless; leaving on its ack avoids holding req for a phantom fetch
        if (bus.imem_ack) begin
          req_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_HALTED: begin
        if (bus.redirect) begin
          fifo_flush = 1'b1;
          pc_d       = bus.redirect_pc;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign fifo_pop = !fifo_empty && bus.id_ready;

  if_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_if_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data ({pc_q, bus.imem_rdata}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = !fifo_empty;
  assign bus.if_pc     = fifo_head[DW-1:16];
  assign bus.if_instr  = fifo_head[15:0];
  assign bus.halted    = (state_q == S_HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed bench for instr_fetch_unit with a latency-programmable memory model
module tb_instr_fetch_unit;

  logic clk;
  logic reset;

  instr_fetch_unit_if #(.PC_W(8), .IMEM_AW(4)) bus ();

  instr_fetch_unit #(.PC_W(8), .IMEM_AW(4), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  logic [15:0] imem [16];
  int          mem_lat;
  int          lat_cnt;
  int          ack_cnt;
  logic        req_prev;
  logic [7:0]  xfer_pc [$];
  logic [15:0] xfer_ins [$];
  logic [3:0]  req_addrs [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; record decode transfers, answer memory requests after mem_lat cycles
  task automatic tick();
    logic        fire;
    logic [7:0]  fpc;
    logic [15:0] fins;
    fire = bus.if_valid && bus.id_ready;
    fpc  = bus.if_pc;
    fins = bus.if_instr;
    @(posedge clk);
    #1;
    if (fire && reset) begin
      xfer_pc.push_back(fpc);
      xfer_ins.push_back(fins);
    end
    if (!reset) begin
      bus.imem_ack = 1'b0;
      lat_cnt      = 0;
    end else if (bus.imem_ack) begin
      bus.imem_ack = 1'b0;
    end else if (bus.imem_req) begin
      if (lat_cnt + 1 >= mem_lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = imem[bus.imem_addr];
        lat_cnt        = 0;
        ack_cnt++;
      end else begin
        lat_cnt++;
      end
    end
    if (bus.imem_req && !req_prev) req_addrs.push_back(bus.imem_addr);
    req_prev = bus.imem_req;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.imem_req), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"},    32'(bus.imem_req),  32'd0);
    chk({tag, "_addr"},   32'(bus.imem_addr), 32'd0);
    chk({tag, "_valid"},  32'(bus.if_valid),  32'd0);
    chk({tag, "_instr"},  32'(bus.if_instr),  32'd0);
    chk({tag, "_pc"},     32'(bus.if_pc),     32'd0);
    chk({tag, "_halted"}, 32'(bus.halted),    32'd0);
  endtask

  initial begin
    n_chk           = 0;
    n_fail          = 0;
    mem_lat         = 1;
    lat_cnt         = 0;
    ack_cnt         = 0;
    req_prev        = 1'b0;
    reset           = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 16'h0;
    bus.id_ready    = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;
    for (int i = 0; i < 16; i++) imem[i] = 16'h1000 | 16'(i);
    imem[0] = 16'h1240;
    imem[1] = 16'h2250;
    imem[2] = 16'hF000;

    // reset values, then first request on the first edge after release
    ticks(2);
    chk_idle("rst");
    reset = 1'b1;
    xfer_pc.delete();
    xfer_ins.delete();
    tick();
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", 32'(bus.imem_addr), 32'd0);
    chk("first_novalid", 32'(bus.if_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(bus.if_valid), 32'd1);
    chk("lat_instr", 32'(bus.if_instr), 32'h1240);
    chk("lat_pc", 32'(bus.if_pc), 32'd0);
    chk("lat_req_drop", 32'(bus.imem_req), 32'd0);

    // three-word program ending in HALT
    ticks(10);
    chk("prog_count", 32'(xfer_pc.size()), 32'd3);
    chk("prog_pc0", 32'(xfer_pc[0]), 32'd0);
    chk("prog_ins0", 32'(xfer_ins[0]), 32'h1240);
    chk("prog_pc1", 32'(xfer_pc[1]), 32'd1);
    chk("prog_ins1", 32'(xfer_ins[1]), 32'h2250);
    chk("prog_pc2", 32'(xfer_pc[2]), 32'd2);
    chk("prog_ins2", 32'(xfer_ins[2]), 32'hF000);
    chk("halted", 32'(bus.halted), 32'd1);
    req_addrs.delete();
    ticks(5);
    chk("halt_no_req", 32'(req_addrs.size()), 32'd0);
    chk("halt_req_low", 32'(bus.imem_req), 32'd0);

    // redirect out of HALTED, decode stalled so the buffer fills
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h03;
    bus.id_ready    = 1'b0;
    ack_cnt         = 0;
    tick();
    bus.redirect = 1'b0;
    chk("unhalt_halted", 32'(bus.halted), 32'd0);
    chk("unhalt_valid", 32'(bus.if_valid), 32'd0);
    tick();
    chk("unhalt_req", 32'(bus.imem_req), 32'd1);
    chk("unhalt_addr", 32'(bus.imem_addr), 32'd3);
    ticks(4);
    chk("stall_mid_instr", 32'(bus.if_instr), 32'h1003);
    ticks(5);
    chk("stall_acks", 32'(ack_cnt), 32'd4);
    chk("stall_req_low", 32'(bus.imem_req), 32'd0);
    chk("stall_valid", 32'(bus.if_valid), 32'd1);
    chk("stall_instr", 32'(bus.if_instr), 32'h1003);
    chk("stall_pc", 32'(bus.if_pc), 32'd3);

    // buffered words drain on consecutive cycles
    bus.id_ready = 1'b1;
    xfer_pc.delete();
    xfer_ins.delete();
    ticks(4);
    chk("drain_count", 32'(xfer_pc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 32'(xfer_pc[i]), 32'(3 + i));
      chk("drain_ins", 32'(xfer_ins[i]), 32'h1003 + 32'(i));
    end

    // reset while a request is outstanding
    wait_req("rst_wait_req");
    reset = 1'b0;
    #1;
    chk_idle("midrst");
    bus.imem_ack = 1'b0;
    bus.id_ready = 1'b0;
    mem_lat      = 3;
    tick();
    reset = 1'b1;
    tick();
    chk("rel_req", 32'(bus.imem_req), 32'd1);
    chk("rel_addr", 32'(bus.imem_addr), 32'd0);

    // redirect in WAIT with a slow ack: drained word is dropped
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h08;
    req_addrs.delete();
    tick();
    bus.redirect = 1'b0;
    chk("drain_req_held", 32'(bus.imem_req), 32'd1);
    chk("drain_addr_held", 32'(bus.imem_addr), 32'd0);
    chk("drain_novalid", 32'(bus.if_valid), 32'd0);
    for (int i = 0; i < 20 && !bus.if_valid; i++) tick();
    chk("redir_valid", 32'(bus.if_valid), 32'd1);
    chk("redir_pc", 32'(bus.if_pc), 32'h08);
    chk("redir_instr", 32'(bus.if_instr), 32'h1008);
    chk("redir_first_addr", 32'(req_addrs[0]), 32'h8);

    // pc wrap from 0xFF to 0x00
    mem_lat         = 1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'hFF;
    tick();
    bus.redirect = 1'b0;
    bus.id_ready = 1'b1;
    xfer_pc.delete();
    xfer_ins.delete();
    req_addrs.delete();
    ticks(12);
    chk("wrap_nreq", 32'(req_addrs.size() >= 2), 32'd1);
    chk("wrap_addr0", 32'(req_addrs[0]), 32'hF);
    chk("wrap_addr1", 32'(req_addrs[1]), 32'h0);
    chk("wrap_nxfer", 32'(xfer_pc.size() >= 2), 32'd1);
    chk("wrap_pc0", 32'(xfer_pc[0]), 32'hFF);
    chk("wrap_ins0", 32'(xfer_ins[0]), 32'h100F);
    chk("wrap_pc1", 32'(xfer_pc[1]), 32'h00);
    chk("wrap_ins1", 32'(xfer_ins[1]), 32'h1240);

    // redirect coincident with ack: that word is discarded
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h04;
    tick();
    bus.redirect = 1'b0;
    wait_req("coin_wait_req");
    chk("coin_ack_up", 32'(bus.imem_ack), 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h05;
    tick();
    bus.redirect = 1'b0;
    xfer_pc.delete();
    xfer_ins.delete();
    chk("coin_req_low", 32'(bus.imem_req), 32'd0);
    chk("coin_novalid", 32'(bus.if_valid), 32'd0);
    tick();
    chk("coin_req", 32'(bus.imem_req), 32'd1);
    chk("coin_addr", 32'(bus.imem_addr), 32'd5);
    ticks(2);
    chk("coin_nxfer", 32'(xfer_pc.size()), 32'd1);
    chk("coin_pc", 32'(xfer_pc[0]), 32'd5);
    chk("coin_ins", 32'(xfer_ins[0]), 32'h1005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
